demux_deser: RTL
================

Name: demux_deser

Overview:
- Synchronous 1-to-2 demultiplexer/deserializer.
- Receives a time-multiplexed serial bit stream, such as the output of the 2:1 bus-switch mux, together with its channel select and active-low enable.
- Steers each bit to channel 0 or 1 and reassembles WIDTH-bit words per channel, with a one-cycle valid pulse per word.
- Sits at the far end of the muxed link and restores the two parallel channels.

Parameters:
- WIDTH, 4: bits per channel word; matches the 4-bit channels of the mux part; must be ≥2.
- CNT_W, 16: width of the transition counter; used only with POWER_COUNT_EN.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- notoe  input  1  active-low enable; 1 means the link is disconnected.
- s  input  1  channel select for the current bit: 0 selects ch0, 1 selects ch1.
- a  input  1  serial data bit.
- y0  output  WIDTH  last complete ch0 word.
- y1  output  WIDTH  last complete ch1 word.
- valid0  output  1  one-cycle pulse when y0 is updated.
- valid1  output  1  one-cycle pulse when y1 is updated.
- activo  output  1  high while the FSM is in HAB.
- trans_count  output  CNT_W  present only with POWER_COUNT_EN.

Behaviour:
- Reset: on any clk edge with reset=1, all of the following clear to 0 regardless of other inputs: y0, y1, valid0, valid1, activo, both shift registers, both bit counters, trans_count. FSM goes to DESHAB.
- FSM states: DESHAB (disabled), HAB (enabled).
- DESHAB → HAB when notoe=0 is sampled. No bit is captured on that edge; one cycle of enable latency.
- HAB → DESHAB when notoe=1 is sampled. The bit on that edge is ignored. Both bit counters clear and partial words are discarded. y0/y1 hold their last complete value. No valid pulse is generated.
- activo = (state==HAB), registered.
- Capture: in HAB with notoe=0, each edge shifts bit a into channel s at position cnt[s], LSB first, then cnt[s] increments. The unselected channel is untouched.
- Word completion: when cnt[s]==WIDTH-1 on a capture edge:
  - y_s <= {a, sr_s[WIDTH-2:0]}
  - valid_s = 1 for exactly the next cycle
  - cnt[s] <= 0
- Latency: y_s and valid_s are visible in the cycle after the edge that captured the last bit.
- Channels are fully independent; interleaving at any granularity is legal and each channel keeps its own partial word.
- valid0 and valid1 can never assert in the same cycle, since only one bit is captured per edge.
- a, s and notoe are sampled only at clk edges. X/Z handling is not modelled; the bench must drive 0/1.
- Reset asserted mid-word: the partial word is lost and no valid pulse is generated.

Optional Feature:
- Macro: POWER_COUNT_EN.
- Defined:
  - trans_count port exists.
  - On each word completion, trans_count += popcount(y_s_old XOR y_s_new), where y_s_old is the channel's previous word.
  - Saturates at 2^CNT_W-1.
  - Cleared by reset.
  - Serves as a switching-activity (dissipated power) proxy, analogous to the mux model's per-transition power count.
- Undefined: the port and all counting logic are absent; all other behaviour is identical.

Decomposition:
- Package demux_pkg:
  - FSM state enum {DESHAB, HAB}
  - default WIDTH constant
  - default CNT_W constant
- Sub-module deser_canal, instantiated twice:
  - one channel's shift register, bit counter, word register and valid pulse
  - inputs: clk, reset, captura (=HAB & ~notoe & s==k), limpiar (abort), a
- Top level: FSM, select decode, optional counter.

Test Plan:
- Enable latency: reset, then notoe=0 with s=0 and a held at 1. Required: the first edge captures nothing and activo rises; after 4 further edges y0=4'hF with valid0 high for one cycle; y1=0.
- Word ch0: in HAB, s=0, a sequence 0,1,0,1 (LSB first). Required: y0=4'hA and valid0 one cycle after the 4th bit; valid1 stays 0.
- Interleave: alternate s=0/1, with ch0 bits 1,1,0,0 and ch1 bits 0,0,1,1. Required: y0=4'h3 on edge 7 (valid0), y1=4'hC on edge 8 (valid1), never simultaneous.
- Abort: ch1 receives 3 bits, then notoe=1 for one cycle, then notoe=0 and 4 bits of 4'h5. Required: y1=4'h5, with no valid1 pulse from the aborted partial word.
- Reset mid-word: 2 bits into ch0, then reset=1 for one edge. Required: all outputs 0 on the next cycle; a subsequent full word decodes correctly.
- POWER_COUNT_EN: ch0 words 4'h0, 4'hF, 4'hA in sequence. Required: trans_count=0, then 4, then 6; with the macro undefined the bench compiles without the port.

Source files
------------

// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared state type and default sizes for demux_deser
package demux_pkg;

    typedef enum logic {
        DESHAB = 1'b0,
        HAB    = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/demux_deser_canal.sv
// rtl/demux_deser_canal.sv - one channel's deserializer: shift register, bit counter, word, valid pulse
// POWER_COUNT_EN adds completion/next-word outputs for the top-level transition counter.
module deser_canal
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_captura,
    input  logic             i_limpiar,
    input  logic             i_a,
    output logic [WIDTH-1:0] o_y,
    output logic             o_valid
`ifdef POWER_COUNT_EN
    ,
    output logic             o_done,
    output logic [WIDTH-1:0] o_word_new
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-2:0] r_sr;
    logic [WIDTH-1:0] r_y;
    logic             r_valid;
    logic             w_last;
    logic [WIDTH-1:0] w_word;

    // The final bit goes straight into the word, so the shift register only holds WIDTH-1 bits.
    assign w_last = i_captura && (r_cnt == CW'(WIDTH - 1));
    assign w_word = {i_a, r_sr};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_sr    <= '0;
            r_y     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_last;
            if (i_limpiar) begin
                r_cnt <= '0;
                r_sr  <= '0;
            end else if (i_captura) begin
                if (w_last) begin
                    r_cnt <= '0;
                    r_y   <= w_word;
                end else begin
                    r_sr[r_cnt] <= i_a;
                    r_cnt       <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign o_y     = r_y;
    assign o_valid = r_valid;
`ifdef POWER_COUNT_EN
    assign o_done     = w_last;
    assign o_word_new = w_word;
`endif

endmodule

// File: rtl/demux_deser.sv
// rtl/demux_deser.sv - 1-to-2 serial demultiplexer/deserializer with enable FSM
// POWER_COUNT_EN adds trans_count, a saturating popcount of word-to-word bit flips.
module demux_deser
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             notoe,
    input  logic             s,
    input  logic             a,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic             valid0,
    output logic             valid1,
    output logic             activo
`ifdef POWER_COUNT_EN
    ,
    output logic [CNT_W-1:0] trans_count
`endif
);

    if (WIDTH < 2 || CNT_W < 1) begin : g_bad_param
        $error("demux_deser: WIDTH must be >= 2 and CNT_W >= 1");
    end

    state_t r_state;
    state_t w_next;
    logic   w_hab;
    logic   w_cap0;
    logic   w_cap1;
    logic   w_abort;

    always_ff @(posedge clk) begin
        if (reset) r_state <= DESHAB;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            DESHAB:  if (!notoe) w_next = HAB;
            HAB:     if (notoe)  w_next = DESHAB;
            default: w_next = DESHAB;
        endcase
    end

    assign w_hab   = (r_state == HAB);
    assign w_cap0  = w_hab && !notoe && !s;
    assign w_cap1  = w_hab && !notoe && s;
    assign w_abort = w_hab && notoe;
    assign activo  = w_hab;

`ifdef POWER_COUNT_EN
    logic             w_done0;
    logic             w_done1;
    logic [WIDTH-1:0] w_new0;
    logic [WIDTH-1:0] w_new1;
    logic [WIDTH-1:0] w_diff;
    logic [CNT_W-1:0] w_pop;
    logic [CNT_W:0]   w_sum;
    logic [CNT_W-1:0] r_tc;
`endif

    deser_canal #(.WIDTH(WIDTH)) u_canal0 (
        .clk       (clk),
        .reset     (reset),
        .i_captura (w_cap0),
        .i_limpiar (w_abort),
        .i_a       (a),
        .o_y       (y0),
        .o_valid   (valid0)
`ifdef POWER_COUNT_EN
        ,
        .o_done    (w_done0),
        .o_word_new(w_new0)
`endif
    );

    deser_canal #(.WIDTH(WIDTH)) u_canal1 (
        .clk       (clk),
        .reset     (reset),
        .i_captura (w_cap1),
        .i_limpiar (w_abort),
        .i_a       (a),
        .o_y       (y1),
        .o_valid   (valid1)
`ifdef POWER_COUNT_EN
        ,
        .o_done    (w_done1),
        .o_word_new(w_new1)
`endif
    );

`ifdef POWER_COUNT_EN
    // At most one channel completes per edge, so one popcount path serves both.
    always_comb begin
        w_diff = w_done0 ? (y0 ^ w_new0) : (y1 ^ w_new1);
        w_pop  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop = w_pop + CNT_W'(w_diff[i]);
        end
        w_sum = {1'b0, r_tc} + {1'b0, w_pop};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tc <= '0;
        end else if (w_done0 || w_done1) begin
            r_tc <= w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
        end
    end

    assign trans_count = r_tc;
`endif

endmodule
